uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: two-requester round-robin arbiter in front of a shared UART
// transmitter. A winning character is latched, handed to the transmitter with
// a registered start request held until busy is seen, and the block then waits
// for a fresh rising edge of done. Each waiting phase is bounded by a timeout
// that drops the character and pulses err_timeout.
module uart_tx_arb #(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              grant_id,
  output logic              err_timeout
);

  // The counter only ever has to reach TIMEOUT_CYC-1 before being cleared;
  // one spare value keeps TIMEOUT_CYC=1 and powers of two safe.
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              grant_q, grant_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;   // requester served most recently
  logic              done_q;           // previous sample of tx_done

  logic              any_valid;
  logic              winner;
  logic [DATA_W-1:0] win_data;
  logic              done_rise;
  logic              cnt_expired;

  // Round-robin winner: a lone requester wins; on contention the requester
  // that was not served last wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      winner = ~last_q;
    end else begin
      winner = req1_valid;
    end
    win_data = winner ? req1_data : req0_data;
  end

  assign req0_ready = (state_q == IDLE) && any_valid && !winner;
  assign req1_ready = (state_q == IDLE) && any_valid &&  winner;

  // Only a low-to-high transition of done completes a frame, so a done level
  // left over from an earlier frame cannot finish the current one.
  assign done_rise   = tx_done & ~done_q;
  assign cnt_expired = (cnt_q == CNT_LAST);

  // Next-state and registered-output logic for the transfer sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    last_d     = last_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (any_valid) begin
          // Data is captured only here; later requester changes are ignored.
          tx_data_d  = win_data;
          grant_d    = winner;
          tx_start_d = 1'b1;
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        if (tx_busy) begin
          // Exit has priority over a timeout landing in the same cycle.
          tx_start_d = 1'b0;
          cnt_d      = '0;
          state_d    = WAIT_DONE;
        end else if (cnt_expired) begin
          tx_start_d = 1'b0;
          err_d      = 1'b1;
          last_d     = grant_q;
          cnt_d      = '0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (done_rise) begin
          last_d  = grant_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_expired) begin
          err_d   = 1'b1;
          last_d  = grant_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        tx_start_d = 1'b0;
        cnt_d      = '0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer silently.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      grant_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      done_q     <= tx_done;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign err_timeout = err_q;

  // Structural invariants of the handshake and sequencing.
  a_ready_onehot : assert property (@(posedge clk) disable iff (!rstn)
    !(req0_ready && req1_ready));
  a_ready_idle : assert property (@(posedge clk) disable iff (!rstn)
    (req0_ready || req1_ready) |-> (state_q == IDLE));
  a_start_issue : assert property (@(posedge clk) disable iff (!rstn)
    tx_start |-> (state_q == ISSUE));
  a_err_pulse : assert property (@(posedge clk) disable iff (!rstn)
    err_timeout |=> !err_timeout);

endmodule
